// File: rtl/pio_clk_pkg.sv
// Shared definitions for the PIO fractional clock-enable generator.
//   INT_W / FRAC_W  : integer and fractional divisor widths
//   CNT_W           : phase counter width, one bit wider than INT_W so a
//                     period of 2^INT_W cycles is representable
//   clkdiv_cfg_t    : {integer divisor, fractional divisor} pair
//   CLKDIV_PASSTHRU : integer divisor value selecting pass-through
//   period_len()    : period length = integer divisor + carry
package pio_clk_pkg;

  localparam int INT_W  = 16;
  localparam int FRAC_W = 8;
  localparam int CNT_W  = INT_W + 1;

  localparam logic [INT_W-1:0] CLKDIV_PASSTHRU = '0;

  typedef struct packed {
    logic [INT_W-1:0]  int_div;
    logic [FRAC_W-1:0] frac;
  } clkdiv_cfg_t;

  function automatic logic [CNT_W-1:0] period_len(input logic [INT_W-1:0] div_i,
                                                  input logic carry_i);
    return {1'b0, div_i} + {{(CNT_W-1){1'b0}}, carry_i};
  endfunction

endpackage

// File: rtl/pio_frac_acc.sv
// Fractional phase accumulator.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : start from zero this cycle (combined with advance it
//                  loads 0 + frac, so a fresh period never carries)
//   advance      : add frac into the accumulator (FRAC_W bits, wraps)
//   frac         : fractional increment
//   carry        : overflow of the add that advance would perform now
module pio_frac_acc
  import pio_clk_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q;
  logic [FRAC_W-1:0] acc_d;
  logic [FRAC_W-1:0] base;
  logic [FRAC_W:0]   sum;

  always_comb begin
    base  = clear ? '0 : acc_q;
    sum   = {1'b0, base} + {1'b0, frac};
    acc_d = acc_q;
    if (advance) begin
      acc_d = sum[FRAC_W-1:0];
    end else if (clear) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign carry = sum[FRAC_W];

endmodule

// File: rtl/pio_frac_clk_enable.sv
// Fractional clock-enable generator for a PIO state machine.
// Average tick rate is clock / (div_int + div_frac/2^FRAC_W); div_int == 0
// is pass-through (a tick for every enabled cycle).
//   clock, reset       : system clock, synchronous active-high reset
//   enable             : run; low freezes the phase without clearing it
//   restart            : clear phase counter and accumulator
//   cfg_wr/cfg_int/cfg_frac : configuration write
//   tick               : registered one-cycle enable
//   cfg_pending        : a written config waits for the period boundary
//   div_int/div_frac   : active divisor readback
//
// Timing model: the phase counter counts enabled clock edges. A period is
// L = div_int + carry edges; the edge that completes the count registers
// tick, so tick is high in the cycle after that edge. The next enabled edge
// starts the following period: the accumulator advances, a pending config
// is applied and the new L is fixed. The restart edge itself counts as the
// first edge of a period, giving a first tick N cycles after restart.
module pio_frac_clk_enable
  import pio_clk_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic              cfg_wr,
  input  logic [INT_W-1:0]  cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              tick,
  output logic              cfg_pending,
  output logic [INT_W-1:0]  div_int,
  output logic [FRAC_W-1:0] div_frac
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  clkdiv_cfg_t      shadow_q, shadow_d;
  clkdiv_cfg_t      active_q, active_d;

  clkdiv_cfg_t      wr_cfg;
  clkdiv_cfg_t      sel_cfg;
  logic [CNT_W-1:0] cur_len;
  logic             boundary;
  logic             acc_clear;
  logic             acc_adv;
  logic             acc_carry;

  assign wr_cfg  = '{int_div: cfg_int, frac: cfg_frac};
  assign cur_len = period_len(active_q.int_div, carry_q);
  // ">=" rather than "==": a divisor written while disabled may shrink the
  // current period below the count already reached, and pass-through has L=0.
  assign boundary = enable && !restart && (cnt_q >= cur_len);

  // Config used for the period starting on this edge, and accumulator
  // control. Kept apart from the next-state block because the carry
  // returned by the accumulator depends on these signals.
  always_comb begin
    sel_cfg   = active_q;
    acc_clear = 1'b0;
    acc_adv   = 1'b0;
    if (restart) begin
      sel_cfg   = cfg_wr ? wr_cfg : active_q;
      acc_clear = 1'b1;
      acc_adv   = (sel_cfg.int_div != CLKDIV_PASSTHRU);
    end else if (boundary) begin
      sel_cfg = pend_q ? shadow_q : active_q;
      acc_adv = (sel_cfg.int_div != CLKDIV_PASSTHRU);
    end
  end

  pio_frac_acc u_acc (
    .clock   (clock),
    .reset   (reset),
    .clear   (acc_clear),
    .advance (acc_adv),
    .frac    (sel_cfg.frac),
    .carry   (acc_carry)
  );

  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    tick_d   = 1'b0;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (restart) begin
      // Restart never ticks on its own edge; a config written alongside it
      // takes effect at once and drops anything pending.
      active_d = sel_cfg;
      if (cfg_wr) begin
        pend_d = 1'b0;
      end
      carry_d = 1'b0;
      cnt_d   = CNT_W'(1);
    end else if (!enable) begin
      if (cfg_wr) begin
        active_d = wr_cfg;
        pend_d   = 1'b0;
      end
    end else begin
      if (boundary) begin
        active_d = sel_cfg;
        pend_d   = 1'b0;
        carry_d  = acc_adv & acc_carry;
        cnt_d    = CNT_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      tick_d = (cnt_d >= period_len(active_d.int_div, carry_d));
      // A write on the boundary edge belongs to the period just started.
      if (cfg_wr) begin
        shadow_d = wr_cfg;
        pend_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      tick_q   <= 1'b0;
      pend_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      tick_q   <= tick_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign tick        = tick_q;
  assign cfg_pending = pend_q;
  assign div_int     = active_q.int_div;
  assign div_frac    = active_q.frac;

endmodule

// File: tb/tb_pio_frac_clk_enable.sv
module tb_pio_frac_clk_enable;

  localparam int EW = 26;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [15:0] cfg_int = '0;
  logic [7:0]  cfg_frac = '0;
  logic        tick;
  logic        cfg_pending;
  logic [15:0] div_int;
  logic [7:0]  div_frac;

  pio_frac_clk_enable dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .cfg_wr      (cfg_wr),
    .cfg_int     (cfg_int),
    .cfg_frac    (cfg_frac),
    .tick        (tick),
    .cfg_pending (cfg_pending),
    .div_int     (div_int),
    .div_frac    (div_frac)
  );

  // clock
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  logic [EW-1:0] exp_q[$];
  int tick_edges[$];

  // reference model: period-level bookkeeping in plain integers
  int m_div = 0, m_frac = 0, m_sdiv = 0, m_sfrac = 0;
  int m_acc = 0, m_carry = 0, m_elapsed = 0;
  logic m_pend = 1'b0, m_tick = 1'b0;

  task automatic model_step(input logic rst, input logic en, input logic rs,
                            input logic wr, input int ci, input int cf);
    int s;
    if (rst) begin
      m_div = 0; m_frac = 0; m_sdiv = 0; m_sfrac = 0;
      m_acc = 0; m_carry = 0; m_elapsed = 0; m_pend = 0; m_tick = 0;
    end else if (rs) begin
      if (wr) begin m_div = ci; m_frac = cf; m_pend = 0; end
      m_acc = (m_div != 0) ? m_frac : 0;
      m_carry = 0; m_elapsed = 1; m_tick = 0;
    end else if (!en) begin
      m_tick = 0;
      if (wr) begin m_div = ci; m_frac = cf; m_pend = 0; end
    end else begin
      if (m_elapsed >= m_div + m_carry) begin
        if (m_pend) begin m_div = m_sdiv; m_frac = m_sfrac; m_pend = 0; end
        if (m_div != 0) begin
          s = m_acc + m_frac;
          m_carry = s / 256;
          m_acc = s % 256;
        end else begin
          m_carry = 0;
        end
        m_elapsed = 1;
      end else begin
        m_elapsed = m_elapsed + 1;
      end
      m_tick = (m_elapsed >= m_div + m_carry);
      if (wr) begin m_sdiv = ci; m_sfrac = cf; m_pend = 1; end
    end
  endtask

  // driver: one clock edge per call
  task automatic step(input logic rst, input logic en, input logic rs,
                      input logic wr, input int ci, input int cf);
    logic [15:0] d16;
    logic [7:0]  f8;
    reset = rst; enable = en; restart = rs; cfg_wr = wr;
    cfg_int = 16'(ci); cfg_frac = 8'(cf);
    @(posedge clock);
    edge_n = edge_n + 1;
    model_step(rst, en, rs, wr, ci, cf);
    d16 = 16'(m_div);
    f8 = 8'(m_frac);
    exp_q.push_back({m_tick, m_pend, d16, f8});
    @(negedge clock);
    #1;
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int tick_at(input int idx);
    if (idx < tick_edges.size()) return tick_edges[idx];
    return -1000000;
  endfunction

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tick, cfg_pending, div_int, div_frac};
      checks = checks + 1;
      if (a !== e) begin
        errors = errors + 1;
        $display("FAIL outputs edge %0d: got tick=%0b pend=%0b int=%0d frac=%0d expected tick=%0b pend=%0b int=%0d frac=%0d",
                 edge_n, a[25], a[24], a[23:8], a[7:0], e[25], e[24], e[23:8], e[7:0]);
      end
      if (tick === 1'b1) tick_edges.push_back(edge_n);
    end
  end

  int r;

  initial begin
    // 1: reset, then pass-through
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    check_val("reset_tick", int'(tick), 0);
    check_val("reset_pending", int'(cfg_pending), 0);
    check_val("reset_div_int", int'(div_int), 0);
    tick_edges.delete();
    run(8, 1'b1);
    check_val("passthru_ticks", tick_edges.size(), 8);

    // 2: int=4, first tick 4 cycles after restart, 16 ticks in 64 cycles
    step(1'b0, 1'b1, 1'b1, 1'b1, 4, 0);
    r = edge_n;
    tick_edges.delete();
    run(64, 1'b1);
    check_val("div4_latency", tick_at(0) + 1 - r, 4);
    check_val("div4_count", tick_edges.size(), 16);

    // 3: int=2 frac=128 -> gaps 2,3,2,3
    step(1'b0, 1'b1, 1'b1, 1'b1, 2, 128);
    r = edge_n;
    tick_edges.delete();
    run(10, 1'b1);
    check_val("frac_count", tick_edges.size(), 4);
    check_val("frac_gap0", tick_at(0) + 1 - r, 2);
    check_val("frac_gap1", tick_at(1) - tick_at(0), 3);
    check_val("frac_gap2", tick_at(2) - tick_at(1), 2);
    check_val("frac_gap3", tick_at(3) - tick_at(2), 3);

    // 4: int=8 running, cfg_wr int=2 at period cycle 3
    step(1'b0, 1'b1, 1'b1, 1'b1, 8, 0);
    r = edge_n;
    tick_edges.delete();
    run(2, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 2, 0);
    check_val("pend_set", int'(cfg_pending), 1);
    check_val("pend_old_div", int'(div_int), 8);
    run(4, 1'b1);
    check_val("pend_at_tick", int'(cfg_pending), 1);
    check_val("tick_at_8", int'(tick), 1);
    run(1, 1'b1);
    check_val("pend_cleared", int'(cfg_pending), 0);
    check_val("new_div", int'(div_int), 2);
    run(4, 1'b1);
    check_val("switch_first", tick_at(0) + 1 - r, 8);
    check_val("switch_gap", tick_at(1) - tick_at(0), 2);
    check_val("switch_count", tick_edges.size(), 3);

    // 5: int=6, enable low for 5 cycles at period cycle 2
    step(1'b0, 1'b1, 1'b1, 1'b1, 6, 0);
    r = edge_n;
    tick_edges.delete();
    run(1, 1'b1);
    run(5, 1'b0);
    run(8, 1'b1);
    check_val("freeze_count", tick_edges.size(), 1);
    check_val("freeze_latency", tick_at(0) + 1 - r, 11);

    // 6: restart+cfg mid-period, then reset mid-period with a pending write
    run(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3, 0);
    r = edge_n;
    tick_edges.delete();
    run(4, 1'b1);
    check_val("restart_latency", tick_at(0) + 1 - r, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 5, 7);
    check_val("pend_before_reset", int'(cfg_pending), 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    check_val("midreset_pending", int'(cfg_pending), 0);
    check_val("midreset_div_int", int'(div_int), 0);
    check_val("midreset_div_frac", int'(div_frac), 0);
    check_val("midreset_tick", int'(tick), 0);

    // 7: maximum period 2^16 (int=65535 with carry)
    step(1'b0, 1'b1, 1'b1, 1'b1, 1, 255);
    step(1'b0, 1'b1, 1'b0, 1'b1, 65535, 255);
    tick_edges.delete();
    run(65540, 1'b1);
    check_val("max_count", tick_edges.size(), 2);
    check_val("max_gap", tick_at(1) - tick_at(0), 65536);

    // 8: randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic rst, en, rs, wr;
      rst = ($urandom_range(0, 399) == 0);
      en  = ($urandom_range(0, 99) < 85);
      rs  = ($urandom_range(0, 39) == 0);
      wr  = ($urandom_range(0, 24) == 0);
      step(rst, en, rs, wr, $urandom_range(0, 5), $urandom_range(0, 255));
    end

    run(2, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
